matrix_frame_receiver: RTL and testbench
========================================

Name: matrix_frame_receiver

Overview:
- Receive end of the serial LED-matrix link: deserializes the srowdata/scoldata stream clocked by sck and rebuilds the 8x8 frame into a parallel matdata bus.
- Used as the capture/checker block for the matrix driver in loop-back builds, and as the input stage of a remote display tile.
- sck is asynchronous to clk; it is oversampled (clk at least 4x sck) with synchronizers and edge detection.
- A frame is committed atomically only when all 8 rows have been received.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on sck, srowdata, scoldata (min 2).
- IDLE_TIMEOUT, 64, clk cycles with no sck rising edge mid-word before the partial word is discarded.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- en  input  1  receive enable; low = ignore link
- sck  input  1  serial clock from driver; data valid on rising edge
- srowdata  input  1  serial row-select bit, MSB first
- scoldata  input  1  serial column-data bit, MSB first
- matdata  output  [7:0][7:0]  last committed frame; matdata[r] = column byte of row r
- frame_valid  output  1  one-cycle pulse when matdata updates
- row_err  output  1  one-cycle pulse on an invalid row word
- busy  output  1  high while a word is partially shifted (bit count != 0)

Behaviour:
- Reset (async, rst=1): matdata=64'h0, frame_valid=0, row_err=0, busy=0, bit count=0, row mask=0, row buffer=0, idle counter=0, synchronizers cleared.
- Sampling: sck, srowdata and scoldata each pass through SYNC_STAGES flops. A rising edge is the synced sck at 1 with its previous synced value at 0. On the clk edge ending the detect cycle, both shift registers shift left, taking the synced data into bit 0.
- Latency, SYNC_STAGES=2:
  - A shift occurs 3 clk after the clk edge that first samples sck high.
  - frame_valid pulses 2 clk after the shift of the final bit of the completing row.
- Word states: IDLE (count 0), SHIFT (count 1..7), DONE (one cycle after the 8th bit).
- DONE handling, using the row word R and column word C:
  - If R is one-hot with bit r set, write C into buffer[r] and set mask[r].
  - If R is zero or has more than one bit set, discard the word, pulse row_err, and leave the mask unchanged.
  - Count returns to 0 in both cases.
- Duplicate row within a frame: buffer[r] is overwritten with the newer byte; the mask does not change.
- Commit: in the cycle after the mask becomes 8'hFF, copy buffer to matdata, pulse frame_valid, and clear the mask. The buffer is not cleared.
- Idle timeout: in SHIFT, the idle counter increments each clk without a detected edge. When it reaches IDLE_TIMEOUT, count resets to 0 and the partial word is dropped silently; the mask is kept. Every detected edge zeroes the idle counter.
- en=0: edges are ignored, count is forced to 0, the mask is held, and matdata is held. The synchronizers keep running. When en rises, reception resumes at the next sck rising edge as bit 7.
- sck rising edge in the same cycle as DONE: the DONE handling above is applied to the completed word, and the new edge shifts in as bit 7 of the next word.
- Reset mid-word or mid-frame: all state clears; a partially received frame is never committed.
- frame_valid and row_err never assert in the same cycle, because commit happens after DONE.

Test Plan:
- Full frame: a bench driver sends rows 0..7 (row word 1<<r, column bytes 77,66,55,44,33,22,11,00 for r=0..7), sck = clk/10 -> exactly one frame_valid; matdata=64'h0011223344556677; row_err never asserts.
- Invalid row: send a row word 8'h03, then 8'h00, within a frame -> two row_err pulses; mask unchanged; the frame commits only after all 8 valid rows are sent.
- Duplicate row: send row 2 with col 8'hAA, then row 2 with 8'h5A, then the remaining rows -> matdata[2]=8'h5A; a single frame_valid.
- Timeout: shift 5 bits, stall sck for 70 clk, then send a full valid word for row 0 col 8'hF0 -> no row_err; busy falls after 64 idle clk; buffer[0]=8'hF0 in the committed frame.
- en gating: with en=0, toggle sck through 16 edges -> busy stays 0 and matdata is unchanged. Raise en, send a full frame -> it commits normally.
- Async reset: assert rst mid-frame, after 5 rows, between clk edges -> matdata=0 and busy=0 immediately. Resend only rows 5..7 -> no frame_valid.

Source files
------------

// File: rtl/matrix_frame_receiver.sv
// matrix_frame_receiver: deserializes the sck/srowdata/scoldata LED-matrix link into an 8x8 frame
// committed atomically once all eight rows have arrived.
module matrix_frame_receiver #(
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            sck,
    input  logic            srowdata,
    input  logic            scoldata,
    output logic [7:0][7:0] matdata,
    output logic            frame_valid,
    output logic            row_err,
    output logic            busy
);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int M  = SYNC_STAGES - 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} word_t;

    logic [M:0]      sck_s, row_s, col_s;
    logic            sck_p, edge_q, row_d, col_d;
    logic [3:0]      cnt;
    logic [7:0]      rsh, csh, mask;
    logic [7:0][7:0] buffer;
    logic [IW-1:0]   idle;
    word_t           ws;

    always_comb ws = (cnt == 4'd0) ? IDLE : (cnt == 4'd8) ? DONE : SHIFT;

    assign busy = cnt != 4'd0;

    // The edge flag is registered so the data sample lines up one cycle behind the synced sck.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sck_s  <= '0;
            row_s  <= '0;
            col_s  <= '0;
            sck_p  <= 1'b0;
            edge_q <= 1'b0;
            row_d  <= 1'b0;
            col_d  <= 1'b0;
        end else begin
            sck_s  <= {sck_s[M-1:0], sck};
            row_s  <= {row_s[M-1:0], srowdata};
            col_s  <= {col_s[M-1:0], scoldata};
            sck_p  <= sck_s[M];
            edge_q <= en & sck_s[M] & ~sck_p;
            row_d  <= row_s[M];
            col_d  <= col_s[M];
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            matdata     <= '0;
            frame_valid <= 1'b0;
            row_err     <= 1'b0;
            cnt         <= '0;
            rsh         <= '0;
            csh         <= '0;
            mask        <= '0;
            buffer      <= '0;
            idle        <= '0;
        end else begin
            frame_valid <= 1'b0;
            row_err     <= 1'b0;
            if (mask == 8'hFF) begin
                matdata     <= buffer;
                frame_valid <= 1'b1;
                mask        <= '0;
            end
            if (!en) begin
                cnt  <= '0;
                idle <= '0;
            end else begin
                if (ws == DONE) begin
                    if ($onehot(rsh)) begin
                        for (int i = 0; i < 8; i++)
                            if (rsh[i]) buffer[i] <= csh;
                        mask <= mask | rsh;
                    end else
                        row_err <= 1'b1;
                end
                if (edge_q) begin
                    rsh  <= {rsh[6:0], row_d};
                    csh  <= {csh[6:0], col_d};
                    cnt  <= (ws == DONE) ? 4'd1 : cnt + 4'd1;
                    idle <= '0;
                end else if (ws == DONE)
                    cnt <= '0;
                else if (ws == SHIFT) begin
                    if (idle == IW'(IDLE_TIMEOUT - 1)) begin
                        cnt  <= '0;
                        idle <= '0;
                    end else
                        idle <= idle + 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_matrix_frame_receiver.sv
// tb_matrix_frame_receiver: directed checks of frame capture, row errors, duplicates,
// idle timeout, enable gating and asynchronous reset.
module tb_matrix_frame_receiver;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b1;
    logic            sck = 1'b0;
    logic            srowdata = 1'b0;
    logic            scoldata = 1'b0;
    logic [7:0][7:0] matdata;
    logic            frame_valid, row_err, busy;

    int n = 0, fails = 0, fv_cnt = 0, re_cnt = 0, fv0, re0;

    matrix_frame_receiver dut (
        .clk(clk), .rst(rst), .en(en), .sck(sck), .srowdata(srowdata),
        .scoldata(scoldata), .matdata(matdata), .frame_valid(frame_valid),
        .row_err(row_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_valid) fv_cnt++;
        if (row_err) re_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int k);
        repeat (k) @(negedge clk);
    endtask

    // sck = clk/10: data set while sck low, captured on the rising edge
    task automatic send_bits(input logic [7:0] r, input logic [7:0] c, input int nb);
        for (int b = 7; b > 7 - nb; b--) begin
            sck = 1'b0;
            srowdata = r[b];
            scoldata = c[b];
            #50;
            sck = 1'b1;
            #50;
        end
        sck = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] r, input logic [7:0] c);
        send_bits(r, c, 8);
    endtask

    initial begin
        #23 rst = 1'b0;
        wclk(2);
        check("reset_matdata", matdata, 64'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_fv", frame_valid, 1'b0);
        check("reset_rowerr", row_err, 1'b0);

        // full frame
        fv0 = fv_cnt; re0 = re_cnt;
        for (int r = 0; r < 8; r++) send_word(8'(1 << r), 8'(8'h77 - 8'h11 * r));
        wclk(20);
        check("full_fv", fv_cnt - fv0, 1);
        check("full_rowerr", re_cnt - re0, 0);
        check("full_matdata", matdata, 64'h0011223344556677);
        check("full_busy", busy, 1'b0);

        // invalid row words mid-frame
        fv0 = fv_cnt; re0 = re_cnt;
        for (int r = 0; r < 3; r++) send_word(8'(1 << r), 8'(r + 1));
        send_word(8'h03, 8'hEE);
        send_word(8'h00, 8'hDD);
        wclk(20);
        check("inv_rowerr", re_cnt - re0, 2);
        check("inv_nofv", fv_cnt - fv0, 0);
        check("inv_hold", matdata, 64'h0011223344556677);
        for (int r = 3; r < 8; r++) send_word(8'(1 << r), 8'(r + 1));
        wclk(20);
        check("inv_fv", fv_cnt - fv0, 1);
        check("inv_matdata", matdata, 64'h0807060504030201);

        // duplicate row
        fv0 = fv_cnt;
        send_word(8'h04, 8'hAA);
        send_word(8'h04, 8'h5A);
        for (int r = 0; r < 8; r++) if (r != 2) send_word(8'(1 << r), 8'(8'h10 + r));
        wclk(20);
        check("dup_fv", fv_cnt - fv0, 1);
        check("dup_matdata", matdata, 64'h17161514135A1110);

        // idle timeout drops a partial word
        fv0 = fv_cnt; re0 = re_cnt;
        send_bits(8'hFF, 8'hFF, 5);
        wclk(30);
        check("to_busy_hi", busy, 1'b1);
        wclk(45);
        check("to_busy_lo", busy, 1'b0);
        send_word(8'h01, 8'hF0);
        for (int r = 1; r < 8; r++) send_word(8'(1 << r), 8'(8'h20 + r));
        wclk(20);
        check("to_rowerr", re_cnt - re0, 0);
        check("to_fv", fv_cnt - fv0, 1);
        check("to_matdata", matdata, 64'h27262524232221F0);

        // enable gating
        fv0 = fv_cnt; re0 = re_cnt;
        en = 1'b0;
        send_bits(8'h01, 8'hFF, 4);
        wclk(1);
        check("en_busy_mid", busy, 1'b0);
        send_bits(8'h01, 8'hFF, 8);
        send_bits(8'h01, 8'hFF, 4);
        wclk(10);
        check("en_busy", busy, 1'b0);
        check("en_hold", matdata, 64'h27262524232221F0);
        check("en_nofv", fv_cnt - fv0, 0);
        en = 1'b1;
        wclk(5);
        for (int r = 0; r < 8; r++) send_word(8'(1 << r), 8'(8'h30 + r));
        wclk(20);
        check("en_fv", fv_cnt - fv0, 1);
        check("en_rowerr", re_cnt - re0, 0);
        check("en_matdata", matdata, 64'h3736353433323130);

        // asynchronous reset mid-frame
        for (int r = 0; r < 5; r++) send_word(8'(1 << r), 8'(8'h40 + r));
        send_bits(8'h20, 8'h45, 3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_matdata", matdata, 64'h0);
        check("arst_busy", busy, 1'b0);
        wclk(2);
        rst = 1'b0;
        wclk(3);
        fv0 = fv_cnt;
        for (int r = 5; r < 8; r++) send_word(8'(1 << r), 8'(8'h40 + r));
        wclk(30);
        check("arst_nofv", fv_cnt - fv0, 0);
        check("arst_matdata2", matdata, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end
endmodule
